// File: rtl/edge_generate_pkg.sv
// Shared definitions for the edge_generate line driver: state encodings and
// a small helper used to size the auto-fall timer.
package edge_generate_pkg;

    // Bit 1 of the encoding is the line level, so signal can be read straight
    // off the state register.
    typedef enum logic [1:0] {
        EG_LOW_HOLD  = 2'd0,
        EG_LOW       = 2'd1,
        EG_HIGH_HOLD = 2'd2,
        EG_HIGH      = 2'd3
    } eg_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_generate_hold_timer.sv
// Loadable down-counter that saturates at zero; expired is high whenever the
// count reads zero, which is also the state right after reset.
module edge_generate_hold_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/edge_generate.sv
// Single-bit line generator driven by rise/fall request pulses, with minimum
// high/low times and a one-deep request queue while a hold is running.
// Optional feature macro: EDGE_GENERATE_PULSE_EN adds pulse_req / PULSE_LEN
// and an auto-fall timer that ends the pulse automatically.
module edge_generate
    import edge_generate_pkg::*;
#(
    parameter int   MIN_HIGH   = 4,
    parameter int   MIN_LOW    = 4,
    parameter int   CNT_WIDTH  = 8,
    parameter logic INIT_LEVEL = 1'b0
`ifdef EDGE_GENERATE_PULSE_EN
    ,
    parameter int   PULSE_LEN  = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic rise_req,
    input  logic fall_req,
`ifdef EDGE_GENERATE_PULSE_EN
    input  logic pulse_req,
`endif
    output logic signal,
    output logic rising,
    output logic falling,
    output logic pending,
    output logic conflict
);

    localparam logic [CNT_WIDTH-1:0] HIGH_LOAD = CNT_WIDTH'(MIN_HIGH - 1);
    localparam logic [CNT_WIDTH-1:0] LOW_LOAD  = CNT_WIDTH'(MIN_LOW - 1);

    eg_state_t            state_q, state_d;
    logic                 pending_d;
    logic                 rising_d, falling_d;
    logic                 up_req, rise_eff, fall_eff, conflict_now;
    logic                 hold_load, hold_expired;
    logic [CNT_WIDTH-1:0] hold_value;
    logic                 want_high, want_low;

`ifdef EDGE_GENERATE_PULSE_EN
    localparam int                   AUTO_LEN  = max_int(PULSE_LEN, MIN_HIGH);
    localparam logic [CNT_WIDTH-1:0] AUTO_LOAD = CNT_WIDTH'(AUTO_LEN - 1);

    logic pulse_q, pulse_d;
    logic pulse_pend_q, pulse_pend_d;
    logic auto_load, auto_expired;

    // A pulse request only counts as a rise while the line is low.
    assign up_req = rise_req | (pulse_req & ~signal);
`else
    assign up_req = rise_req;
`endif

    assign conflict_now = up_req & fall_req;
    assign rise_eff     = up_req & ~fall_req;
    assign fall_eff     = fall_req & ~up_req;
    assign signal       = state_q[1];

    edge_generate_hold_timer #(.CNT_WIDTH(CNT_WIDTH)) u_hold_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .load_value(hold_value),
        .expired   (hold_expired)
    );

`ifdef EDGE_GENERATE_PULSE_EN
    edge_generate_hold_timer #(.CNT_WIDTH(CNT_WIDTH)) u_auto_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (auto_load),
        .load_value(AUTO_LOAD),
        .expired   (auto_expired)
    );
`endif

    // Next-state logic. The counter is always zero in LOW/HIGH, so "hold
    // expired" doubles as "an edge is allowed this cycle" in every state.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending;
        rising_d   = 1'b0;
        falling_d  = 1'b0;
        hold_load  = 1'b0;
        hold_value = HIGH_LOAD;
        want_high  = 1'b0;
        want_low   = 1'b0;
`ifdef EDGE_GENERATE_PULSE_EN
        pulse_d      = pulse_q;
        pulse_pend_d = pulse_pend_q;
        auto_load    = 1'b0;
`endif
        if (!signal) begin
            if (fall_eff) begin
                pending_d = 1'b0;
`ifdef EDGE_GENERATE_PULSE_EN
                pulse_pend_d = 1'b0;
`endif
            end else if (rise_eff) begin
                if (hold_expired) begin
                    want_high = 1'b1;
                end else begin
                    pending_d = 1'b1;
`ifdef EDGE_GENERATE_PULSE_EN
                    pulse_pend_d = pulse_pend_q | pulse_req;
`endif
                end
            end
            if (hold_expired && pending && !fall_eff) begin
                want_high = 1'b1;
            end
            if (want_high) begin
                state_d    = EG_HIGH_HOLD;
                hold_load  = 1'b1;
                hold_value = HIGH_LOAD;
                pending_d  = 1'b0;
                rising_d   = 1'b1;
`ifdef EDGE_GENERATE_PULSE_EN
                pulse_pend_d = 1'b0;
                pulse_d      = pulse_pend_q | (rise_eff & pulse_req);
                auto_load    = pulse_pend_q | (rise_eff & pulse_req);
`endif
            end else if (hold_expired) begin
                state_d = EG_LOW;
            end
        end else begin
            if (rise_eff) begin
                pending_d = 1'b0;
`ifdef EDGE_GENERATE_PULSE_EN
                pulse_d = 1'b0;
`endif
            end else if (fall_eff) begin
                if (hold_expired) begin
                    want_low = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end
            if (hold_expired && pending && !rise_eff) begin
                want_low = 1'b1;
            end
`ifdef EDGE_GENERATE_PULSE_EN
            if (pulse_q && auto_expired && !rise_eff) begin
                want_low = 1'b1;
            end
`endif
            if (want_low) begin
                state_d    = EG_LOW_HOLD;
                hold_load  = 1'b1;
                hold_value = LOW_LOAD;
                pending_d  = 1'b0;
                falling_d  = 1'b1;
`ifdef EDGE_GENERATE_PULSE_EN
                pulse_d = 1'b0;
`endif
            end else if (hold_expired) begin
                state_d = EG_HIGH;
            end
        end
    end

    // State, queue flag and registered one-cycle output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT_LEVEL ? EG_HIGH : EG_LOW;
            pending  <= 1'b0;
            rising   <= 1'b0;
            falling  <= 1'b0;
            conflict <= 1'b0;
`ifdef EDGE_GENERATE_PULSE_EN
            pulse_q      <= 1'b0;
            pulse_pend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pending  <= pending_d;
            rising   <= rising_d;
            falling  <= falling_d;
            conflict <= conflict_now;
`ifdef EDGE_GENERATE_PULSE_EN
            pulse_q      <= pulse_d;
            pulse_pend_q <= pulse_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_edge_generate.sv
// Directed testbench for edge_generate (default parameters, INIT_LEVEL=0).
// Each step drives one cycle of requests and pushes the outputs expected
// after that clock edge; the expectation is popped and checked #1 later.
module tb_edge_generate;

    typedef struct packed {
        logic sig;
        logic ris;
        logic fal;
        logic pen;
        logic con;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rise_req = 1'b0;
    logic fall_req = 1'b0;
    logic pulse_req = 1'b0;
    logic signal, rising, falling, pending, conflict;

    exp_t sb[$];
    int   test_count = 0;
    int   fail_count = 0;
    int   step_no = 0;

    edge_generate dut (
        .clk      (clk),
        .rst      (rst),
        .rise_req (rise_req),
        .fall_req (fall_req),
`ifdef EDGE_GENERATE_PULSE_EN
        .pulse_req(pulse_req),
`endif
        .signal   (signal),
        .rising   (rising),
        .falling  (falling),
        .pending  (pending),
        .conflict (conflict)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        test_count++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s step %0d: observed %b expected %b", tag, step_no, obs, expv);
        end
    endtask

    task automatic check_output();
        exp_t e;
        test_count++;
        assert (sb.size() > 0) else begin
            fail_count++;
            $error("[TB] FAIL scoreboard step %0d: observed empty queue expected entry", step_no);
            return;
        end
        e = sb.pop_front();
        check_bit("signal",   signal,   e.sig);
        check_bit("rising",   rising,   e.ris);
        check_bit("falling",  falling,  e.fal);
        check_bit("pending",  pending,  e.pen);
        check_bit("conflict", conflict, e.con);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, clock, check.
    task automatic apply_stimulus(input logic r, input logic rq, input logic fq, input logic pq,
                                  input logic s, input logic ri, input logic fa,
                                  input logic pe, input logic co);
        exp_t e;
        rst       = r;
        rise_req  = rq;
        fall_req  = fq;
        pulse_req = pq;
        e = '{sig: s, ris: ri, fal: fa, pen: pe, con: co};
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        check_output();
    endtask

    initial begin
        @(posedge clk);
        #1;
        //              rst rise fall pulse | sig ris fal pen con
        apply_stimulus(1, 0, 0, 0,   0, 0, 0, 0, 0); // reset
        apply_stimulus(0, 1, 0, 0,   1, 1, 0, 0, 0); // rise from LOW, latency 1
        apply_stimulus(0, 0, 1, 0,   1, 0, 0, 1, 0); // fall during high hold queues
        apply_stimulus(0, 0, 0, 0,   1, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0,   1, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0,   0, 0, 1, 0, 0); // falls after exactly 4 high cycles
        apply_stimulus(0, 1, 0, 0,   0, 0, 0, 1, 0); // rise in low hold queues
        apply_stimulus(0, 0, 1, 0,   0, 0, 0, 0, 0); // same-level fall cancels
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0); // no edge ever appeared
        apply_stimulus(0, 1, 1, 0,   0, 0, 0, 0, 1); // conflict in LOW
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0); // conflict lasts one cycle
        apply_stimulus(0, 0, 1, 0,   0, 0, 0, 0, 0); // same-level fall in LOW: nothing
        apply_stimulus(0, 1, 0, 0,   1, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0,   1, 0, 0, 1, 0); // pending mid-hold
        apply_stimulus(1, 0, 0, 0,   0, 0, 0, 0, 0); // reset discards hold and pending
        apply_stimulus(0, 1, 0, 0,   1, 1, 0, 0, 0); // edge allowed right after reset
        apply_stimulus(0, 1, 0, 0,   1, 0, 0, 0, 0); // same-level rise in high hold
        apply_stimulus(0, 0, 0, 0,   1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0,   1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0,   0, 0, 1, 0, 0); // fall exactly at hold expiry
        apply_stimulus(0, 1, 1, 0,   0, 0, 0, 0, 1); // conflict in low hold
        apply_stimulus(0, 1, 0, 0,   0, 0, 0, 1, 0);
        apply_stimulus(0, 1, 0, 0,   0, 0, 0, 1, 0); // merged second request
        apply_stimulus(0, 0, 0, 0,   1, 1, 0, 0, 0); // executes after 4 low cycles
        apply_stimulus(0, 1, 1, 0,   1, 0, 0, 0, 1); // conflict in high hold
        apply_stimulus(0, 0, 0, 0,   1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0,   1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0,   0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0);
`ifdef EDGE_GENERATE_PULSE_EN
        apply_stimulus(0, 0, 0, 1,   1, 1, 0, 0, 0); // pulse start
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(0, 0, 0, 0,   1, 0, 0, 0, 0);
        end
        apply_stimulus(0, 0, 0, 0,   0, 0, 1, 0, 0); // auto-fall after 8 high cycles
        apply_stimulus(0, 0, 0, 0,   0, 0, 0, 0, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
